// File: rtl/wb_tgt_pkg.sv
// Shared types and helpers for the pipelined Wishbone register-file target.
// Data, select and read-tag widths live here because the response record is built from them.
package wb_tgt_pkg;

  localparam int LATENCY_MAX = 8;
  localparam int DAT_WIDTH   = 16;
  localparam int SEL_WIDTH   = 2;
  localparam int TGRD_WIDTH  = 1;
  localparam int LANE_W      = DAT_WIDTH / SEL_WIDTH;

  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [DAT_WIDTH-1:0]  dat;
    logic [TGRD_WIDTH-1:0] tgd;
  } rsp_t;

  // Expands each byte select into a full lane of ones.
  function automatic logic [DAT_WIDTH-1:0] sel2mask(input logic [SEL_WIDTH-1:0] sel);
    logic [DAT_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      m[i*LANE_W +: LANE_W] = {LANE_W{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_tgt_regfile_if.sv
// Pipelined Wishbone bus bundle, named from the target's point of view.
// The initiator side uses the master modport, the register file uses slave.
interface wb_tgt_regfile_if
  import wb_tgt_pkg::*;
#(
  parameter int ADR_WIDTH  = 4,
  parameter int TGWD_WIDTH = 1
);

  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic                  lock_i;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic [ADR_WIDTH-1:0]  adr_i;
  logic [DAT_WIDTH-1:0]  dat_i;
  logic [TGWD_WIDTH-1:0] tgd_i;
  logic                  ack_o;
  logic                  err_o;
  logic                  rty_o;
  logic                  stall_o;
  logic [DAT_WIDTH-1:0]  dat_o;
  logic [TGRD_WIDTH-1:0] tgd_o;

  modport master (
    output cyc_i, stb_i, we_i, lock_i, sel_i, adr_i, dat_i, tgd_i,
    input  ack_o, err_o, rty_o, stall_o, dat_o, tgd_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, lock_i, sel_i, adr_i, dat_i, tgd_i,
    output ack_o, err_o, rty_o, stall_o, dat_o, tgd_o
  );

endinterface

// File: rtl/wb_tgt_rsp_pipe.sv
// Fixed-latency response delay line; the last stage is the bus response.
// A flush empties every stage at the next edge and masks the current output.
module wb_tgt_rsp_pipe
  import wb_tgt_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  rsp_t                  rsp_i,
  output logic                  vld_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DAT_WIDTH-1:0]  dat_o,
  output logic [TGRD_WIDTH-1:0] tgd_o
);

  rsp_t stg_q [LATENCY];
  rsp_t out_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LATENCY; i++) stg_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < LATENCY; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= rsp_i;
      for (int i = 1; i < LATENCY; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  // Output stage: a dropped cycle must not see the response sitting in the last stage.
  assign out_s = stg_q[LATENCY-1];
  assign vld_o = out_s.vld & ~flush_i;
  assign ack_o = vld_o & ~out_s.err;
  assign err_o = vld_o & out_s.err;
  assign dat_o = ack_o ? out_s.dat : '0;
  assign tgd_o = ack_o ? out_s.tgd : '0;

endmodule

// File: rtl/wb_tgt_regfile.sv
// Pipelined Wishbone target: byte-selectable register file with fixed response
// latency, throttled by an outstanding-request budget.
module wb_tgt_regfile
  import wb_tgt_pkg::*;
#(
  parameter int ADR_WIDTH  = 4,
  parameter int WORDS      = 12,
  parameter int TGWD_WIDTH = 1,
  parameter int LATENCY    = 3,
  parameter int MAX_OUT    = 2
) (
  input  logic           clk_i,
  input  logic           async_rst_n_i,
  wb_tgt_regfile_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [DAT_WIDTH-1:0]  mem_q [WORDS];
  logic [TGWD_WIDTH-1:0] tag_q [WORDS];
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [ADR_WIDTH-1:0]  idx;
  logic [DAT_WIDTH-1:0]  wmask;
  logic                  in_range, stall, accept, wr_en, rsp_done;
  rsp_t                  rsp_in;
  logic                  unused_lock;

  assign unused_lock = bus.lock_i;

  assign idx      = bus.adr_i;
  assign in_range = ({1'b0, bus.adr_i} < (ADR_WIDTH+1)'(WORDS));
  assign stall    = bus.cyc_i & (out_cnt_q == CNT_W'(MAX_OUT));
  assign accept   = bus.cyc_i & bus.stb_i & ~stall;
  assign wr_en    = accept & bus.we_i & in_range;
  assign wmask    = sel2mask(bus.sel_i);

  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[idx] <= (mem_q[idx] & ~wmask) | (bus.dat_i & wmask);
      tag_q[idx] <= bus.tgd_i;
    end
  end

  // Read data is captured at accept so a later write cannot alter an in-flight response.
  always_comb begin
    rsp_in     = '0;
    rsp_in.vld = accept;
    rsp_in.err = ~in_range;
    if (!bus.we_i && in_range) begin
      rsp_in.dat = mem_q[idx];
      rsp_in.tgd = TGRD_WIDTH'(tag_q[idx]);
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (!bus.cyc_i) begin
      out_cnt_d = '0;
    end else begin
      case ({accept, rsp_done})
        2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
        2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
        default: out_cnt_d = out_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) out_cnt_q <= '0;
    else                out_cnt_q <= out_cnt_d;
  end

  wb_tgt_rsp_pipe #(.LATENCY(LATENCY)) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_n_i (async_rst_n_i),
    .flush_i (~bus.cyc_i),
    .rsp_i   (rsp_in),
    .vld_o   (rsp_done),
    .ack_o   (bus.ack_o),
    .err_o   (bus.err_o),
    .dat_o   (bus.dat_o),
    .tgd_o   (bus.tgd_o)
  );

  assign bus.rty_o   = 1'b0;
  assign bus.stall_o = stall;

endmodule

// File: tb/tb_wb_tgt_regfile.sv
// Bench for wb_tgt_regfile: vector table, corner-case sequences and random
// traffic, all checked against a queue-based model of the bus contract.
module tb_wb_tgt_regfile;

  localparam int LAT  = 3;
  localparam int MAXO = 2;
  localparam int NW   = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_tgt_regfile_if #(.ADR_WIDTH(4), .TGWD_WIDTH(1)) bus ();

  wb_tgt_regfile #(
    .ADR_WIDTH(4), .WORDS(NW), .TGWD_WIDTH(1), .LATENCY(LAT), .MAX_OUT(MAXO)
  ) dut (
    .clk_i         (clk),
    .async_rst_n_i (rst_n),
    .bus           (bus)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [15:0] dat;
    logic        tgd;
  } exp_t;

  typedef struct {
    logic        cyc, stb, we;
    logic [3:0]  adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic        tgd;
    logic        ack, err, stall;
    logic [15:0] rdat;
    logic        rtgd;
  } vec_t;

  exp_t        q[$];
  logic [15:0] mm [NW];
  logic        mt [NW];
  int          now = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        obs_ack, obs_err, obs_stall, obs_tgd;
  logic [15:0] obs_dat;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", nm, now, got, exp);
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < NW; i++) begin
      mm[i] = '0;
      mt[i] = 1'b0;
    end
  endtask

  // One bus cycle: drive, predict, sample on the falling edge, advance the model.
  task automatic step(input logic c, input logic s, input logic w, input logic [3:0] a,
                      input logic [1:0] sl, input logic [15:0] d, input logic t,
                      output logic acc);
    logic        e_stall, rsp, e_ack, e_err, e_tgd;
    logic [15:0] e_dat;
    exp_t        e;
    bus.cyc_i  = c;
    bus.stb_i  = s;
    bus.we_i   = w;
    bus.adr_i  = a;
    bus.sel_i  = sl;
    bus.dat_i  = d;
    bus.tgd_i  = t;
    bus.lock_i = 1'($urandom_range(0, 1));
    e_stall = c && (q.size() == MAXO);
    acc     = c && s && !e_stall;
    rsp     = c && (q.size() > 0) && (q[0].due == now);
    e_ack = 1'b0; e_err = 1'b0; e_dat = '0; e_tgd = 1'b0;
    if (rsp) begin
      e_err = q[0].err;
      e_ack = !q[0].err;
      e_dat = q[0].dat;
      e_tgd = q[0].tgd;
    end
    @(negedge clk);
    obs_ack = bus.ack_o; obs_err = bus.err_o; obs_stall = bus.stall_o;
    obs_dat = bus.dat_o; obs_tgd = bus.tgd_o;
    chk("ack", {31'd0, obs_ack}, {31'd0, e_ack});
    chk("err", {31'd0, obs_err}, {31'd0, e_err});
    chk("stall", {31'd0, obs_stall}, {31'd0, e_stall});
    chk("dat", {16'd0, obs_dat}, {16'd0, e_dat});
    chk("tgd", {31'd0, obs_tgd}, {31'd0, e_tgd});
    chk("rty", {31'd0, bus.rty_o}, 32'd0);
    if (rsp) e = q.pop_front();
    if (acc) begin
      e.due = now + LAT;
      e.err = (int'(a) >= NW);
      e.dat = '0;
      e.tgd = 1'b0;
      if (!e.err && !w) begin
        e.dat = mm[a];
        e.tgd = mt[a];
      end
      if (!e.err && w) begin
        if (sl[0]) mm[a][7:0]  = d[7:0];
        if (sl[1]) mm[a][15:8] = d[15:8];
        mt[a] = t;
      end
      q.push_back(e);
    end
    if (!c) q.delete();
    now++;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic c, logic s, logic w, logic [3:0] a, logic [1:0] sl,
                              logic [15:0] d, logic t, logic ea, logic ee, logic es,
                              logic [15:0] ed, logic et);
    vec_t v;
    v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.sel = sl; v.dat = d; v.tgd = t;
    v.ack = ea; v.err = ee; v.stall = es; v.rdat = ed; v.rtgd = et;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[20];
    logic acc;
    int   r, acks, errs, first_st;

    vt[0]  = mk(1,1,0,4'd5, 2'b00,16'h0000,0, 0,0,0,16'h0000,0);
    vt[1]  = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,0,0,16'h0000,0);
    vt[2]  = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,0,0,16'h0000,0);
    vt[3]  = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 1,0,0,16'h0000,0);
    vt[4]  = mk(1,1,1,4'd2, 2'b10,16'hA5C3,1, 0,0,0,16'h0000,0);
    vt[5]  = mk(1,1,0,4'd2, 2'b00,16'h0000,0, 0,0,0,16'h0000,0);
    vt[6]  = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,0,1,16'h0000,0);
    vt[7]  = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 1,0,1,16'h0000,0);
    vt[8]  = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 1,0,0,16'hA500,1);
    vt[9]  = mk(1,1,0,4'd13,2'b00,16'h0000,0, 0,0,0,16'h0000,0);
    vt[10] = mk(1,1,1,4'd15,2'b11,16'hFFFF,1, 0,0,0,16'h0000,0);
    vt[11] = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,0,1,16'h0000,0);
    vt[12] = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,1,1,16'h0000,0);
    vt[13] = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,1,0,16'h0000,0);
    vt[14] = mk(1,1,0,4'd3, 2'b00,16'h0000,0, 0,0,0,16'h0000,0);
    vt[15] = mk(1,1,0,4'd2, 2'b00,16'h0000,0, 0,0,0,16'h0000,0);
    vt[16] = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,0,1,16'h0000,0);
    vt[17] = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 1,0,1,16'h0000,0);
    vt[18] = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 1,0,0,16'hA500,1);
    vt[19] = mk(1,0,0,4'd0, 2'b00,16'h0000,0, 0,0,0,16'h0000,0);

    model_clear();
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.lock_i = 0;
    bus.sel_i = '0; bus.adr_i = '0; bus.dat_i = '0; bus.tgd_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Post-reset idle outputs.
    step(0,0,0,4'd0,2'b00,16'h0,0,acc);
    step(1,0,0,4'd0,2'b00,16'h0,0,acc);

    for (int i = 0; i < 20; i++) begin
      step(vt[i].cyc, vt[i].stb, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, vt[i].tgd, acc);
      chk($sformatf("v%0d_ack", i),   {31'd0, obs_ack},   {31'd0, vt[i].ack});
      chk($sformatf("v%0d_err", i),   {31'd0, obs_err},   {31'd0, vt[i].err});
      chk($sformatf("v%0d_stall", i), {31'd0, obs_stall}, {31'd0, vt[i].stall});
      chk($sformatf("v%0d_dat", i),   {16'd0, obs_dat},   {16'd0, vt[i].rdat});
      chk($sformatf("v%0d_tgd", i),   {31'd0, obs_tgd},   {31'd0, vt[i].rtgd});
    end

    // Back-to-back reads with stb held.
    for (int i = 0; i < 4; i++) begin
      step(1,1,1,4'(i),2'b11,16'h1000 + 16'(i) * 16'h0111,1'(i),acc);
      repeat (3) step(1,0,0,4'd0,2'b00,16'h0,0,acc);
    end
    r = 0; acks = 0; first_st = -1;
    for (int c = 0; c < 14; c++) begin
      step(1, (r < 4), 0, 4'(r), 2'b00, 16'h0, 0, acc);
      if (acc) r++;
      if (obs_ack) acks++;
      if (obs_stall && first_st < 0) first_st = c;
    end
    chk("b2b_accepts", r, 4);
    chk("b2b_acks", acks, 4);
    chk("b2b_first_stall", first_st, 2);

    // Abort with two reads in flight.
    step(1,1,0,4'd1,2'b00,16'h0,0,acc);
    step(1,1,0,4'd2,2'b00,16'h0,0,acc);
    acks = 0; errs = 0;
    for (int c = 0; c < 5; c++) begin
      step(0,1,0,4'd3,2'b00,16'h0,0,acc);
      if (obs_ack) acks++;
      if (obs_err) errs++;
      chk("abort_stall", {31'd0, obs_stall}, 32'd0);
    end
    chk("abort_acks", acks, 0);
    chk("abort_errs", errs, 0);
    step(1,1,0,4'd2,2'b00,16'h0,0,acc);
    chk("abort_restart_accept", {31'd0, acc}, 32'd1);
    step(1,1,0,4'd3,2'b00,16'h0,0,acc);
    chk("abort_restart_stall", {31'd0, obs_stall}, 32'd0);
    repeat (4) step(1,0,0,4'd0,2'b00,16'h0,0,acc);

    // Asynchronous reset pulse with two reads in flight.
    step(1,1,1,4'd7,2'b11,16'hBEEF,1,acc);
    repeat (3) step(1,0,0,4'd0,2'b00,16'h0,0,acc);
    step(1,1,0,4'd7,2'b00,16'h0,0,acc);
    step(1,1,0,4'd1,2'b00,16'h0,0,acc);
    bus.stb_i = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_ack",   {31'd0, bus.ack_o},   32'd0);
    chk("rst_err",   {31'd0, bus.err_o},   32'd0);
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("rst_dat",   {16'd0, bus.dat_o},   32'd0);
    chk("rst_tgd",   {31'd0, bus.tgd_o},   32'd0);
    rst_n = 1'b1;
    model_clear();
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      step(1,0,0,4'd0,2'b00,16'h0,0,acc);
      if (obs_ack || obs_err) acks++;
    end
    chk("rst_no_rsp", acks, 0);
    step(1,1,0,4'd7,2'b00,16'h0,0,acc);
    repeat (2) step(1,0,0,4'd0,2'b00,16'h0,0,acc);
    step(1,0,0,4'd0,2'b00,16'h0,0,acc);
    chk("rst_readback_ack", {31'd0, obs_ack}, 32'd1);
    chk("rst_readback_dat", {16'd0, obs_dat}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom_range(0, 1)), acc);
    end
    repeat (3) step(0,0,0,4'd0,2'b00,16'h0,0,acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
